// File: rtl/serial_adder_mux_ctrl_if.sv
// serial_adder_mux_ctrl_if
//   Bundles the request/result handshake and the 4:1 mux full-adder hookup
//   of the bit-serial adder controller.
//   Request side : start, op_a, op_b, cin          (into the controller)
//   Result side  : busy, done, sum, cout           (out of the controller)
//   Mux side     : mux_sel, mux_d (out), mux_y (in, combinational sum bit)
//
//   Handshake: a request is taken on a rising edge where start=1 and busy=0.
//   op_a/op_b/cin are sampled on that same edge. start while busy=1 is
//   dropped (no queueing). done is a one-cycle pulse; sum/cout are valid from
//   that cycle on and hold until the next result overwrites them.
//
//   modport slave  : the controller
//   modport master : the requester plus the external mux (drives mux_y)
interface serial_adder_mux_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic [1:0]       mux_sel;
  logic [3:0]       mux_d;
  logic             mux_y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport slave (
    input  start, op_a, op_b, cin, mux_y,
    output mux_sel, mux_d, busy, done, sum, cout
  );

  modport master (
    output start, op_a, op_b, cin, mux_y,
    input  mux_sel, mux_d, busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_mux_ctrl.sv
// serial_adder_mux_ctrl
//   Bit-serial WIDTH-bit adder controller feeding an external combinational
//   4:1 mux that acts as the full adder. Each RUN cycle the current operand
//   bit pair selects a mux input and the mux data carries carry-derived
//   values, so the mux output is the sum bit for that position. One sum bit
//   per clock, LSB first; the running carry is kept here.
//
//   Ports
//     clk       in   rising-edge clock
//     rst_n     in   synchronous active-low reset
//     bus       slave modport of serial_adder_mux_ctrl_if
//     state_dbg out  current FSM state (IDLE=0, RUN=1, DONE=2)
module serial_adder_mux_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_adder_mux_ctrl_if.slave  bus,
  output logic [1:0]              state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_r;
  logic             c;
  logic             cout_r;
  logic [CW-1:0]    cnt;

  logic             in_run;
  logic             accept;
  logic             c_next;
  logic [WIDTH-1:0] sum_next;

  assign in_run   = (state == RUN);
  // DONE counts as not busy, so a new request can start back-to-back.
  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign c_next   = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
  // mux_y is the sum bit of the current position; shift it in from the top
  // so that after WIDTH cycles bit 0 of sum_sh holds the LSB.
  assign sum_next = {bus.mux_y, sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_r  <= '0;
      c      <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      state  <= RUN;
      a_sh   <= bus.op_a;
      b_sh   <= bus.op_b;
      c      <= bus.cin;
      cnt    <= '0;
      sum_sh <= '0;
    end else begin
      case (state)
        RUN: begin
          sum_sh <= sum_next;
          c      <= c_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state  <= DONE;
            // Capture the finished result directly so sum/cout are already
            // valid in the cycle done is high.
            sum_r  <= sum_next;
            cout_r <= c_next;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Mux mapping: input k = {a_i,b_i}. Inputs 0 and 3 (bits equal) give c,
  // inputs 1 and 2 (bits differ) give ~c, i.e. a_i ^ b_i ^ c.
  assign bus.mux_sel = in_run ? {a_sh[0], b_sh[0]} : 2'b00;
  assign bus.mux_d   = in_run ? {c, ~c, ~c, c} : 4'b0000;
  assign bus.busy    = in_run;
  assign bus.done    = (state == DONE);
  assign bus.sum     = sum_r;
  assign bus.cout    = cout_r;
  assign state_dbg   = state;

endmodule
